// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter defaults and the receiver state encoding.
package uart_pkg;

   localparam int unsigned DefOversample = 16;
   localparam int unsigned DefDataBits   = 8;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input; resets to 1 (idle level of a UART line).
module uart_sync2 (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1 by default); mid-bit sampling, LSB first.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = DefOversample,
   parameter int unsigned DATA_BITS  = DefDataBits
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 baud_clk_en,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 rx_valid,
   output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 rx_busy
);

   localparam int unsigned TickW = $clog2(OVERSAMPLE);
   localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TickW-1:0] HalfTick = TickW'(OVERSAMPLE / 2 - 1);
   localparam logic [TickW-1:0] LastTick = TickW'(OVERSAMPLE - 1);
   localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);

   uart_state_e          state_q;
   logic                 rx_s;
   logic                 rx_prev_q;
   logic [TickW-1:0]     tick_cnt_q;
   logic [BitW-1:0]      bit_cnt_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 rx_valid_q;
   logic                 frame_err_q;
   logic                 rx_busy_q;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad_q;
   logic                 parity_err_q;
`endif

   uart_sync2 u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (rx_in),
      .q_o     (rx_s)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         rx_prev_q    <= 1'b1;
         tick_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         data_q       <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_prev_q   <= rx_s;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         unique case (state_q)
            // Edge, not level: a line stuck low after a frame error never retriggers.
            StIdle: begin
               if (rx_prev_q && !rx_s) begin
                  state_q    <= StStart;
                  tick_cnt_q <= '0;
                  rx_busy_q  <= 1'b1;
               end
            end
            StStart: begin
               if (baud_clk_en) begin
                  if (tick_cnt_q == HalfTick) begin
                     tick_cnt_q <= '0;
                     if (!rx_s) begin
                        state_q   <= StData;
                        bit_cnt_q <= '0;
                     end else begin
                        state_q   <= StIdle;
                        rx_busy_q <= 1'b0;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + TickW'(1);
                  end
               end
            end
            StData: begin
               if (baud_clk_en) begin
                  if (tick_cnt_q == LastTick) begin
                     tick_cnt_q <= '0;
                     shreg_q    <= {rx_s, shreg_q[DATA_BITS-1:1]};
                     bit_cnt_q  <= bit_cnt_q + BitW'(1);
                     if (bit_cnt_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= StParity;
`else
                        state_q <= StStop;
`endif
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + TickW'(1);
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (baud_clk_en) begin
                  if (tick_cnt_q == LastTick) begin
                     tick_cnt_q <= '0;
                     par_bad_q  <= ^{shreg_q, rx_s};
                     state_q    <= StStop;
                  end else begin
                     tick_cnt_q <= tick_cnt_q + TickW'(1);
                  end
               end
            end
`endif
            StStop: begin
               if (baud_clk_en) begin
                  if (tick_cnt_q == LastTick) begin
                     tick_cnt_q <= '0;
                     state_q    <= StIdle;
                     rx_busy_q  <= 1'b0;
                     if (rx_s) begin
                        data_q     <= shreg_q;
                        rx_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_bad_q;
`endif
                     end else begin
                        frame_err_q <= 1'b1;
                     end
                  end else begin
                     tick_cnt_q <= tick_cnt_q + TickW'(1);
                  end
               end
            end
            default: begin
               state_q   <= StIdle;
               rx_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign data_out  = data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign rx_busy   = rx_busy_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx; baud tick every 4 clk, 16 ticks per bit.
module tb_uart_rx;

   localparam int BitClk = 64;

   logic       clk;
   logic       reset_n;
   logic       baud_clk_en;
   logic       rx_in;
   logic [7:0] data_out;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   logic [1:0] div_q;
   int         n_cmp;
   int         n_err;
   int         valid_cnt;
   int         ferr_cnt;
   int         perr_cnt;
   int         both_cnt;
   int         busy_seen;
   logic [7:0] got [0:31];
   int         base;

   uart_rx #(
      .OVERSAMPLE (16),
      .DATA_BITS  (8)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .baud_clk_en (baud_clk_en),
      .rx_in       (rx_in),
      .data_out    (data_out),
      .rx_valid    (rx_valid),
      .frame_err   (frame_err),
`ifdef UART_RX_PARITY_EN
      .parity_err  (parity_err),
`endif
      .rx_busy     (rx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial div_q = 2'd0;
   always @(posedge clk) div_q <= div_q + 2'd1;
   assign baud_clk_en = (div_q == 2'd3);

   always @(negedge clk) begin
      if (reset_n) begin
         if (rx_valid) begin
            got[valid_cnt % 32] = data_out;
            valid_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) perr_cnt++;
`endif
         end
         if (frame_err) ferr_cnt++;
         if (rx_valid && frame_err) both_cnt++;
         if (rx_busy) busy_seen = 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic line_bit(input logic b, input int clks);
      rx_in = b;
      repeat (clks) @(negedge clk);
   endtask

   // Start, 8 data LSB first, [even parity ^ par_flip], stop.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
      @(negedge clk);
      line_bit(1'b0, BitClk);
      for (int i = 0; i < 8; i++) line_bit(d[i], BitClk);
`ifdef UART_RX_PARITY_EN
      line_bit((^d) ^ par_flip, BitClk);
`else
      if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
      line_bit(stop_bit, BitClk);
      rx_in = 1'b1;
   endtask

   initial begin
      n_cmp = 0; n_err = 0; valid_cnt = 0; ferr_cnt = 0; perr_cnt = 0;
      both_cnt = 0; busy_seen = 0;
      rx_in   = 1'b1;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset data_out", 32'(data_out), 32'h0);
      check("reset rx_valid", 32'(rx_valid), 32'h0);
      check("reset frame_err", 32'(frame_err), 32'h0);
      check("reset rx_busy", 32'(rx_busy), 32'h0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);

      // 1. Good frame 0xA5
      send_frame(8'hA5, 1'b1, 1'b0);
      repeat (16) @(negedge clk);
      check("t1 valid count", 32'(valid_cnt), 32'd1);
      check("t1 data_out", 32'(data_out), 32'hA5);
      check("t1 frame_err count", 32'(ferr_cnt), 32'd0);
      check("t1 idle busy", 32'(rx_busy), 32'h0);

      // 2. Start glitch of 3 ticks
      busy_seen = 0;
      @(negedge clk);
      line_bit(1'b0, 12);
      rx_in = 1'b1;
      repeat (100) @(negedge clk);
      check("t2 busy seen", 32'(busy_seen), 32'd1);
      check("t2 busy low", 32'(rx_busy), 32'h0);
      check("t2 valid count", 32'(valid_cnt), 32'd1);
      check("t2 frame_err count", 32'(ferr_cnt), 32'd0);

      // 3. 0x3C with stop low; line stays low into stop, must not retrigger
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (200) @(negedge clk);
      check("t3 frame_err count", 32'(ferr_cnt), 32'd1);
      check("t3 valid count", 32'(valid_cnt), 32'd1);
      check("t3 data_out kept", 32'(data_out), 32'hA5);
      check("t3 idle busy", 32'(rx_busy), 32'h0);

      // 4. Back-to-back 0x00 then 0xFF
      base = valid_cnt;
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      repeat (16) @(negedge clk);
      check("t4 valid count", 32'(valid_cnt - base), 32'd2);
      check("t4 first byte", 32'(got[base % 32]), 32'h00);
      check("t4 second byte", 32'(got[(base + 1) % 32]), 32'hFF);
      check("t4 data_out", 32'(data_out), 32'hFF);

      // 5. Reset during bit 4 of 0x12
      @(negedge clk);
      line_bit(1'b0, BitClk);
      line_bit(1'b0, BitClk);
      line_bit(1'b1, BitClk);
      line_bit(1'b0, BitClk);
      line_bit(1'b0, BitClk);
      line_bit(1'b1, BitClk / 2);
      check("t5 busy before reset", 32'(rx_busy), 32'h1);
      reset_n = 1'b0;
      #1;
      check("t5 reset data_out", 32'(data_out), 32'h0);
      check("t5 reset busy", 32'(rx_busy), 32'h0);
      check("t5 reset valid", 32'(rx_valid), 32'h0);
      check("t5 reset frame_err", 32'(frame_err), 32'h0);
      rx_in = 1'b1;
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      base = valid_cnt;
      send_frame(8'h5A, 1'b1, 1'b0);
      repeat (16) @(negedge clk);
      check("t5 valid count", 32'(valid_cnt - base), 32'd1);
      check("t5 data_out", 32'(data_out), 32'h5A);

`ifdef UART_RX_PARITY_EN
      // 6. 0x81 with wrong parity bit (1)
      base = valid_cnt;
      send_frame(8'h81, 1'b1, 1'b1);
      repeat (16) @(negedge clk);
      check("t6 valid count", 32'(valid_cnt - base), 32'd1);
      check("t6 parity_err count", 32'(perr_cnt), 32'd1);
      check("t6 data_out", 32'(data_out), 32'h81);
`endif

      check("frame_err with rx_valid", 32'(both_cnt), 32'd0);
      check("total frame_err", 32'(ferr_cnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
